// File: rtl/mem_access_seq.sv
// Purpose : sequences one load/store from the MEM stage onto a word-only,
//           variable-latency data memory, with RMW for sb/sh and sub-word load extension.
// Latency : load/sw 3 cycles, sb/sh 4 cycles, error 2 cycles, plus one per memory wait cycle.
// Backpressure: holds stall until rsp_valid. Holds mem_req until mem_ack or the wait-counter timeout.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   req_valid/we/addr/wdata/dmtype  access from the MEM stage, latched on leaving IDLE
//   stall                       pipeline freeze, req_valid & ~rsp_valid
//   rsp_valid/rdata/err         one-cycle completion pulse with extended load data / error
//   mem_req/we/addr/wdata       word request to memory, stable until acked
//   mem_rdata, mem_ack          memory read word and completion strobe
module mem_access_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [2:0] DT_W  = 3'b000;
  localparam logic [2:0] DT_H  = 3'b001;
  localparam logic [2:0] DT_B  = 3'b010;
  localparam logic [2:0] DT_HU = 3'b011;
  localparam logic [2:0] DT_BU = 3'b100;

  // Counter value in the last permitted wait cycle; an ack in that cycle still wins.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      dt_q, dt_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  logic misaligned;
  logic illegal;

  // Select the addressed byte/half and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  dt);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (dt)
      DT_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
      DT_HU:   load_extract = {16'h0000, sh[15:0]};
      DT_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
      DT_BU:   load_extract = {24'h000000, sh[7:0]};
      default: load_extract = word;
    endcase
  endfunction

  // Overlay the store byte/half onto the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  off,
                                              input logic [2:0]  dt);
    logic [31:0] mask;
    logic [31:0] data;
    if (dt == DT_H) begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'h0000, wd} << {off[1], 4'b0000};
    end else begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'h000000, wd[7:0]} << {off, 3'b000};
    end
    store_merge = (word & ~mask) | (data & mask);
  endfunction

  assign misaligned = ((req_dmtype == DT_W) && (req_addr[1:0] != 2'b00)) ||
                      (((req_dmtype == DT_H) || (req_dmtype == DT_HU)) && req_addr[0]);
  // Unsigned variants exist only for loads.
  assign illegal    = (req_dmtype > DT_BU) ||
                      (req_we && ((req_dmtype == DT_HU) || (req_dmtype == DT_BU)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    off_d       = off_q;
    dt_d        = dt_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          off_d   = req_addr[1:0];
          dt_d    = req_dmtype;
          wdata_d = req_wdata[15:0];
          cnt_d   = '0;
          if (misaligned || illegal) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_dmtype == DT_W)) begin
              state_d     = WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d  = RD;
              mem_we_d = 1'b0;
            end
          end
        end
      end

      RD: begin
        if (mem_ack) begin
          if (we_q) begin
            state_d     = WR;
            cnt_d       = '0;
            mem_we_d    = 1'b1;
            mem_wdata_d = store_merge(mem_rdata, wdata_q, off_q, dt_q);
          end else begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_extract(mem_rdata, off_q, dt_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR: begin
        if (mem_ack) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      dt_q        <= 3'b000;
      wdata_q     <= 16'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      off_q       <= off_d;
      dt_q        <= dt_d;
      wdata_q     <= wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign stall     = req_valid & ~rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Purpose : randomized and directed checking of mem_access_seq against a transaction-level model.
// Latency : n/a (bench).
// Backpressure: the bench plays both pipeline and memory, with chosen per-phase wait latencies.
module tb_mem_access_seq;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;
  localparam int NEVER   = 99;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_dmtype = 3'b000;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_access_seq #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_words [logic [29:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [29:0] i);
    if (mem_words.exists(i)) return mem_words[i];
    return {i, 2'b00} ^ 32'h5A3C_96E1;
  endfunction

  // Access legality from the access-type table.
  function automatic bit model_illegal(input logic we, input logic [1:0] off, input logic [2:0] dt);
    case (dt)
      3'd0:    return off != 2'd0;
      3'd1:    return off[0];
      3'd2:    return 1'b0;
      3'd3:    return we || off[0];
      3'd4:    return we;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off, input logic [2:0] dt);
    logic [7:0] b [4];
    int o;
    int hb;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    o  = int'(off);
    hb = o & 2;
    case (dt)
      3'd2:    return {{24{b[o][7]}}, b[o]};
      3'd4:    return {24'h0, b[o]};
      3'd1:    return {{16{b[hb+1][7]}}, b[hb+1], b[hb]};
      3'd3:    return {16'h0, b[hb+1], b[hb]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [2:0] dt);
    logic [7:0] b [4];
    int o;
    int hb;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    o  = int'(off);
    hb = o & 2;
    case (dt)
      3'd1: begin b[hb] = wd[7:0]; b[hb+1] = wd[15:8]; end
      3'd2: b[o] = wd[7:0];
      default: return wd;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_dmtype = 3'($urandom);
      mem_ack    = 1'($urandom);
      mem_rdata  = $urandom;
      #1;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
    end
  endtask

  // One access: plays pipeline and memory, checks every cycle against the model timeline.
  // A latency >= TIMEOUT means the memory never acks that phase.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] dt, input int rd_lat, input int wr_lat,
                        input int rst_at, input bit scramble,
                        output logic [31:0] got_rdata, output logic got_err,
                        output int got_rd_n, output int got_wr_n, output int got_stall_n);
    logic [29:0] idx;
    logic [31:0] old_word, exp_rdata, exp_wword, ph_wd;
    logic        exp_err, rmw, in_phase, ph_we, seen, aborted;
    int          t, exp_rsp, exp_rd_n, exp_wr_n, k, wcnt, lat;

    idx      = addr[31:2];
    old_word = mem_get(idx);
    exp_err  = model_illegal(we, addr[1:0], dt);
    rmw      = we && (dt == 3'd1 || dt == 3'd2);
    exp_rd_n = 0;
    exp_wr_n = 0;
    t        = 1;
    if (!exp_err) begin
      if (!we || rmw) begin
        exp_rd_n = 1;
        if (rd_lat >= TIMEOUT) begin t += TIMEOUT; exp_err = 1'b1; end
        else t += rd_lat + 1;
      end
      if (we && !exp_err) begin
        exp_wr_n = 1;
        if (wr_lat >= TIMEOUT) begin t += TIMEOUT; exp_err = 1'b1; end
        else t += wr_lat + 1;
      end
    end
    exp_rsp   = t + 1;
    exp_rdata = 32'h0;
    if (!we && !exp_err) exp_rdata = model_load(old_word, addr[1:0], dt);
    exp_wword = model_store(old_word, wdata, addr[1:0], dt);

    got_rdata = 32'h0; got_err = 1'b0; got_rd_n = 0; got_wr_n = 0; got_stall_n = 0;
    in_phase = 1'b0; ph_we = 1'b0; ph_wd = 32'h0; wcnt = 0; seen = 1'b0; aborted = 1'b0; k = 0;

    while (!seen && !aborted && k < 64) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = dt;
      end else if (scramble) begin
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_dmtype = 3'($urandom);
      end
      #1;
      if (k == rst_at) begin
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        aborted   = 1'b1;
      end else begin
        chk("rsp_valid_timing", 32'(rsp_valid), 32'(k == exp_rsp));
        chk("stall", 32'(stall), 32'(k != exp_rsp));
        if (stall) got_stall_n++;
        if (rsp_valid) begin
          seen = 1'b1; got_rdata = rsp_rdata; got_err = rsp_err;
        end
        if (mem_req) begin
          chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
          if (!in_phase) begin
            in_phase = 1'b1; ph_we = mem_we; ph_wd = mem_wdata; wcnt = 0;
            if (mem_we) begin
              got_wr_n++;
              chk("mem_wdata", mem_wdata, exp_wword);
            end else got_rd_n++;
          end else begin
            chk("mem_we_stable", 32'(mem_we), 32'(ph_we));
            if (ph_we) chk("mem_wdata_stable", mem_wdata, ph_wd);
          end
          lat = ph_we ? wr_lat : rd_lat;
          if (wcnt == lat) begin
            mem_ack  = 1'b1;
            in_phase = 1'b0;
            if (ph_we) mem_words[idx] = mem_wdata;
            else mem_rdata = mem_get(idx);
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
          end
        end else begin
          in_phase  = 1'b0;
          // Stray acks outside a request must be ignored.
          mem_ack   = 1'($urandom_range(0, 3) == 0);
          mem_rdata = $urandom;
        end
      end
    end

    if (!aborted) begin
      if (!seen) begin
        checks++; errors++;
        $display("FAIL rsp_missing: no rsp_valid within %0d cycles, expected in cycle %0d", k, exp_rsp);
      end
      chk("rsp_err", 32'(got_err), 32'(exp_err));
      chk("rsp_rdata", got_rdata, exp_rdata);
      chk("rd_phases", 32'(got_rd_n), 32'(exp_rd_n));
      chk("wr_phases", 32'(got_wr_n), 32'(exp_wr_n));
      if (we && !exp_err) chk("mem_word", mem_get(idx), exp_wword);
      else chk("mem_word_kept", mem_get(idx), old_word);
    end
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 9))
      6:       return TIMEOUT - 1;
      7:       return TIMEOUT;
      8:       return NEVER;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [31:0] rd, a;
    logic        er, we;
    logic [2:0]  dt;
    int          nr, nw, ns;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rstn = 1'b1;

    // lw with two wait cycles
    mem_words[30'h40] = 32'hDEADBEEF;
    do_txn(1'b0, 32'h100, 32'h0, 3'd0, 2, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(ns), 32'd4);
    chk("lw_err", 32'(er), 32'd0);

    // sub-word loads
    mem_words[30'h40] = 32'h80FF1234;
    do_txn(1'b0, 32'h103, 32'h0, 3'd2, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_stall_cycles", 32'(ns), 32'd2);
    do_txn(1'b0, 32'h103, 32'h0, 3'd4, 1, 0, 0, 1'b1, rd, er, nr, nw, ns);
    chk("lbu_rdata", rd, 32'h00000080);
    do_txn(1'b0, 32'h102, 32'h0, 3'd1, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lh_rdata", rd, 32'hFFFF80FF);
    do_txn(1'b0, 32'h102, 32'h0, 3'd3, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lhu_rdata", rd, 32'h000080FF);

    // read-modify-write stores
    mem_words[30'h40] = 32'h11223344;
    do_txn(1'b1, 32'h101, 32'h000000AB, 3'd2, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("sb_word", mem_get(30'h40), 32'h1122AB44);
    chk("sb_err", 32'(er), 32'd0);
    chk("sb_stall_cycles", 32'(ns), 32'd3);
    mem_words[30'h40] = 32'h11223344;
    do_txn(1'b1, 32'h102, 32'h00005566, 3'd1, 1, 2, 0, 1'b1, rd, er, nr, nw, ns);
    chk("sh_word", mem_get(30'h40), 32'h55663344);

    // decode errors
    do_txn(1'b0, 32'h102, 32'h0, 3'd0, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lw_misaligned_err", 32'(er), 32'd1);
    chk("lw_misaligned_reqs", 32'(nr + nw), 32'd0);
    do_txn(1'b1, 32'h101, 32'h1234, 3'd1, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    do_txn(1'b1, 32'h100, 32'hAB, 3'd4, 0, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("sbu_illegal_err", 32'(er), 32'd1);
    chk("sbu_illegal_rdata", rd, 32'd0);

    // timeouts and the ack-on-last-cycle boundary
    do_txn(1'b0, 32'h100, 32'h0, 3'd0, NEVER, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lw_timeout_err", 32'(er), 32'd1);
    chk("lw_timeout_stall", 32'(ns), 32'd16);
    do_txn(1'b1, 32'h101, 32'hCC, 3'd2, NEVER, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("sb_timeout_err", 32'(er), 32'd1);
    chk("sb_timeout_writes", 32'(nw), 32'd0);
    do_txn(1'b0, 32'h100, 32'h0, 3'd0, TIMEOUT - 1, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("lw_last_ack_err", 32'(er), 32'd0);
    chk("lw_last_ack_rdata", rd, 32'h55663344);

    // reset in the middle of the write phase of an sb
    do_txn(1'b1, 32'h101, 32'hEE, 3'd2, 0, NEVER, 4, 1'b0, rd, er, nr, nw, ns);
    @(negedge clk);
    rstn = 1'b1;
    idle(3);
    do_txn(1'b0, 32'h100, 32'h0, 3'd0, 1, 0, 0, 1'b0, rd, er, nr, nw, ns);
    chk("post_rst_lw_rdata", rd, 32'h55663344);
    chk("post_rst_lw_err", 32'(er), 32'd0);

    // randomized traffic over a small window so RMWs overlap earlier writes
    for (int n = 0; n < 300; n++) begin
      a  = 32'h200 + 32'($urandom_range(0, 31));
      dt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      we = 1'($urandom);
      do_txn(we, a, $urandom, dt, pick_lat(), pick_lat(), 0,
             ($urandom_range(0, 3) == 0), rd, er, nr, nw, ns);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
